pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Decode-stage pipeline controller: hazard detection, operand bypass selection,
// control-flow and exception steering, plus a level-interrupt acceptance FSM.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dec_inst,
    input  logic        dec_valid,
    input  logic        dec_zero,
    input  logic        dec_super,
    input  logic        irq,
    output logic        stall,
    output logic [1:0]  ir_src_if,
    output logic [1:0]  ir_src_dec,
    output logic [2:0]  pc_sel,
    output logic [1:0]  byp_a_sel,
    output logic [1:0]  byp_b_sel,
    output logic        irq_ack
);

    localparam logic [1:0] IR_SRC_DATA   = 2'b00;
    localparam logic [1:0] IR_SRC_NOP    = 2'b01;
    localparam logic [1:0] IR_SRC_EXCEPT = 2'b10;

    localparam logic [2:0] PC_INC    = 3'b000;
    localparam logic [2:0] PC_BRANCH = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_ILLOP  = 3'b011;
    localparam logic [2:0] PC_XADR   = 3'b100;

    localparam logic [1:0] BYP_RF  = 2'b00;
    localparam logic [1:0] BYP_EX  = 2'b01;
    localparam logic [1:0] BYP_MEM = 2'b10;
    localparam logic [1:0] BYP_WB  = 2'b11;

    localparam logic [4:0] REG_XP = 5'd30;
    localparam logic [4:0] REG_ZERO = 5'd31;

    typedef enum logic [1:0] {
        IRQ_IDLE      = 2'b00,
        IRQ_PEND      = 2'b01,
        IRQ_WAIT_DROP = 2'b10
    } irq_state_t;

    irq_state_t irq_state_q, irq_state_d;

    logic       ex_valid_q,  ex_valid_d;
    logic [4:0] ex_dest_q,   ex_dest_d;
    logic       ex_load_q,   ex_load_d;
    logic       mem_valid_q, mem_valid_d;
    logic [4:0] mem_dest_q,  mem_dest_d;
    logic       mem_load_q,  mem_load_d;
    logic       wb_valid_q,  wb_valid_d;
    logic [4:0] wb_dest_q,   wb_dest_d;

    logic [5:0] opcode;
    logic [4:0] rc, ra, rb, src_b;
    logic       is_ld, is_st, is_jmp, is_beq, is_bne, is_ldr, is_alu, is_aluc;
    logic       legal, illegal, use_a, use_b;
    logic       a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    logic       load_use, irq_take;
    logic       unused_bits;

    assign unused_bits = ^dec_inst[10:0];

    // A stage matches a source only if it will write that register; R31 is hardwired zero.
    function automatic logic stage_hit(input logic v, input logic [4:0] d, input logic [4:0] s);
        return v && (d == s) && (s != REG_ZERO);
    endfunction

    always_comb begin
        opcode  = dec_inst[31:26];
        rc      = dec_inst[25:21];
        ra      = dec_inst[20:16];
        rb      = dec_inst[15:11];
        is_ld   = (opcode == 6'b011000);
        is_st   = (opcode == 6'b011001);
        is_jmp  = (opcode == 6'b011011);
        is_beq  = (opcode == 6'b011100);
        is_bne  = (opcode == 6'b011101);
        is_ldr  = (opcode == 6'b011111);
        is_alu  = (opcode[5:4] == 2'b10);
        is_aluc = (opcode[5:4] == 2'b11);
        legal   = is_ld | is_st | is_jmp | is_beq | is_bne | is_ldr | is_alu | is_aluc;
        illegal = dec_valid & ~legal;
        use_a   = dec_valid & legal & ~is_ldr;
        use_b   = dec_valid & (is_st | is_alu);
        src_b   = is_st ? rc : rb;

        a_ex  = use_a & stage_hit(ex_valid_q,  ex_dest_q,  ra);
        a_mem = use_a & stage_hit(mem_valid_q, mem_dest_q, ra);
        a_wb  = use_a & stage_hit(wb_valid_q,  wb_dest_q,  ra);
        b_ex  = use_b & stage_hit(ex_valid_q,  ex_dest_q,  src_b);
        b_mem = use_b & stage_hit(mem_valid_q, mem_dest_q, src_b);
        b_wb  = use_b & stage_hit(wb_valid_q,  wb_dest_q,  src_b);

        load_use = ((a_ex | b_ex) & ex_load_q) | ((a_mem | b_mem) & mem_load_q);
        irq_take = (irq_state_q == IRQ_PEND) & irq & dec_valid & ~dec_super & ~illegal;
    end

    // Decode-slot resolution, highest priority first.
    always_comb begin
        stall      = 1'b0;
        ir_src_if  = IR_SRC_DATA;
        ir_src_dec = IR_SRC_NOP;
        pc_sel     = PC_INC;
        byp_a_sel  = BYP_RF;
        byp_b_sel  = BYP_RF;
        irq_ack    = 1'b0;
        if (rst) begin
            ir_src_if = IR_SRC_NOP;
        end else if (dec_valid) begin
            byp_a_sel = a_ex ? BYP_EX : a_mem ? BYP_MEM : a_wb ? BYP_WB : BYP_RF;
            byp_b_sel = b_ex ? BYP_EX : b_mem ? BYP_MEM : b_wb ? BYP_WB : BYP_RF;
            if (illegal) begin
                ir_src_dec = IR_SRC_EXCEPT;
                ir_src_if  = IR_SRC_NOP;
                pc_sel     = PC_ILLOP;
            end else if (irq_take) begin
                ir_src_dec = IR_SRC_EXCEPT;
                ir_src_if  = IR_SRC_NOP;
                pc_sel     = PC_XADR;
                irq_ack    = 1'b1;
            end else if (load_use) begin
                stall = 1'b1;
            end else begin
                ir_src_dec = IR_SRC_DATA;
                if (is_jmp) begin
                    pc_sel    = PC_JUMP;
                    ir_src_if = IR_SRC_NOP;
                end else if ((is_beq && dec_zero) || (is_bne && !dec_zero)) begin
                    pc_sel    = PC_BRANCH;
                    ir_src_if = IR_SRC_NOP;
                end
            end
        end
    end

    always_comb begin
        irq_state_d = irq_state_q;
        case (irq_state_q)
            IRQ_IDLE:      if (irq) irq_state_d = IRQ_PEND;
            IRQ_PEND:      if (irq_take) irq_state_d = IRQ_WAIT_DROP;
                           else if (!irq) irq_state_d = IRQ_IDLE;
            IRQ_WAIT_DROP: if (!irq) irq_state_d = IRQ_IDLE;
            default:       irq_state_d = IRQ_IDLE;
        endcase
    end

    // Injected exceptions write the return address into R30; stores write nothing.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_dest_d  = 5'd0;
        ex_load_d  = 1'b0;
        if (ir_src_dec == IR_SRC_EXCEPT) begin
            ex_valid_d = 1'b1;
            ex_dest_d  = REG_XP;
        end else if (ir_src_dec == IR_SRC_DATA && !stall) begin
            ex_valid_d = ~is_st;
            ex_dest_d  = rc;
            ex_load_d  = is_ld | is_ldr;
        end
        mem_valid_d = ex_valid_q;
        mem_dest_d  = ex_dest_q;
        mem_load_d  = ex_load_q;
        wb_valid_d  = mem_valid_q;
        wb_dest_d   = mem_dest_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_state_q <= IRQ_IDLE;
            ex_valid_q  <= 1'b0;
            ex_dest_q   <= 5'd0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= 5'd0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= 5'd0;
        end else begin
            irq_state_q <= irq_state_d;
            ex_valid_q  <= ex_valid_d;
            ex_dest_q   <= ex_dest_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_dest_q  <= mem_dest_d;
            mem_load_q  <= mem_load_d;
            wb_valid_q  <= wb_valid_d;
            wb_dest_q   <= wb_dest_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: bypass, load-use stalls, branches, illegal
// opcodes, interrupt handshake and reset abandonment.
module tb_pipe_ctrl;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_LD  = 6'b011000;
    localparam logic [5:0] OP_ST  = 6'b011001;
    localparam logic [5:0] OP_JMP = 6'b011011;
    localparam logic [5:0] OP_BEQ = 6'b011100;
    localparam logic [5:0] OP_BNE = 6'b011101;
    localparam logic [5:0] OP_ILL = 6'b000000;

    logic        clk;
    logic        rst;
    logic [31:0] dec_inst;
    logic        dec_valid;
    logic        dec_zero;
    logic        dec_super;
    logic        irq;
    logic        stall;
    logic [1:0]  ir_src_if;
    logic [1:0]  ir_src_dec;
    logic [2:0]  pc_sel;
    logic [1:0]  byp_a_sel;
    logic [1:0]  byp_b_sel;
    logic        irq_ack;

    int checks = 0;
    int failures = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .dec_inst(dec_inst), .dec_valid(dec_valid),
        .dec_zero(dec_zero), .dec_super(dec_super), .irq(irq),
        .stall(stall), .ir_src_if(ir_src_if), .ir_src_dec(ir_src_dec),
        .pc_sel(pc_sel), .byp_a_sel(byp_a_sel), .byp_b_sel(byp_b_sel),
        .irq_ack(irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rc, ra, rb, 11'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic e_stall, input logic [1:0] e_if,
                            input logic [1:0] e_dec, input logic [2:0] e_pc);
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".ir_src_if"}, 32'(ir_src_if), 32'(e_if));
        chk({tag, ".ir_src_dec"}, 32'(ir_src_dec), 32'(e_dec));
        chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(e_pc));
    endtask

    task automatic chk_byp(input string tag, input logic [1:0] e_a, input logic [1:0] e_b);
        chk({tag, ".byp_a"}, 32'(byp_a_sel), 32'(e_a));
        chk({tag, ".byp_b"}, 32'(byp_b_sel), 32'(e_b));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic r, input logic v, input logic [31:0] inst);
        rst = r;
        dec_valid = v;
        dec_inst = inst;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush(input string tag);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'd0);
            chk_ctrl(tag, 1'b0, 2'b00, 2'b01, 3'b000);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; dec_valid = 1'b1; dec_inst = mk(OP_ADD, 1, 2, 3);
        dec_zero = 1'b0; dec_super = 1'b0; irq = 1'b0;

        // Reset values
        drive(1'b1, 1'b1, mk(OP_ADD, 1, 2, 3));
        chk_ctrl("rst", 1'b0, 2'b01, 2'b01, 3'b000);
        chk_byp("rst", 2'b00, 2'b00);
        chk("rst.ack", 32'(irq_ack), 32'd0);
        tick();
        drive(1'b1, 1'b1, mk(OP_ADD, 1, 2, 3));
        tick();

        // ALU bypass chain and priority
        drive(1'b0, 1'b1, mk(OP_ADD, 1, 2, 3));
        chk_ctrl("add1", 1'b0, 2'b00, 2'b00, 3'b000);
        chk_byp("add1", 2'b00, 2'b00);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 4, 1, 1));
        chk_ctrl("add_r1r1", 1'b0, 2'b00, 2'b00, 3'b000);
        chk_byp("add_r1r1", 2'b01, 2'b01);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 6, 1, 2));
        chk_byp("mem_byp", 2'b10, 2'b00);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 31, 4, 1));
        chk_byp("mem_wb_byp", 2'b10, 2'b11);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 7, 31, 6));
        chk_byp("r31_nobyp", 2'b00, 2'b10);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 7, 2, 3));
        chk_byp("no_match", 2'b00, 2'b00);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 8, 7, 31));
        chk_byp("ex_over_mem", 2'b01, 2'b00);
        tick();
        flush("flush1");

        // Load-use: EX match stalls two cycles, then WB bypass
        drive(1'b0, 1'b1, mk(OP_LD, 5, 2, 0));
        chk_ctrl("ld", 1'b0, 2'b00, 2'b00, 3'b000);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 9, 5, 3));
        chk_ctrl("lu1", 1'b1, 2'b00, 2'b01, 3'b000);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 9, 5, 3));
        chk_ctrl("lu2", 1'b1, 2'b00, 2'b01, 3'b000);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 9, 5, 3));
        chk_ctrl("lu_go", 1'b0, 2'b00, 2'b00, 3'b000);
        chk_byp("lu_go", 2'b11, 2'b00);
        tick();

        // Store data bypass, then MEM-only load match stalls one cycle
        drive(1'b0, 1'b1, mk(OP_LD, 5, 2, 0));
        tick();
        drive(1'b0, 1'b1, mk(OP_ST, 9, 2, 0));
        chk_ctrl("st", 1'b0, 2'b00, 2'b00, 3'b000);
        chk_byp("st", 2'b00, 2'b10);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 10, 2, 5));
        chk_ctrl("lu_mem", 1'b1, 2'b00, 2'b01, 3'b000);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 10, 2, 5));
        chk_ctrl("lu_mem_go", 1'b0, 2'b00, 2'b00, 3'b000);
        chk_byp("lu_mem_go", 2'b00, 2'b11);
        tick();
        flush("flush2");

        // Control flow
        dec_zero = 1'b1;
        drive(1'b0, 1'b1, mk(OP_BEQ, 10, 2, 0));
        chk_ctrl("beq_t", 1'b0, 2'b01, 2'b00, 3'b001);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        chk_ctrl("beq_after", 1'b0, 2'b00, 2'b01, 3'b000);
        tick();
        drive(1'b0, 1'b1, mk(OP_BNE, 11, 2, 0));
        chk_ctrl("bne_nt", 1'b0, 2'b00, 2'b00, 3'b000);
        tick();
        dec_zero = 1'b0;
        drive(1'b0, 1'b1, mk(OP_BNE, 11, 2, 0));
        chk_ctrl("bne_t", 1'b0, 2'b01, 2'b00, 3'b001);
        tick();
        drive(1'b0, 1'b1, mk(OP_JMP, 12, 2, 0));
        chk_ctrl("jmp", 1'b0, 2'b01, 2'b00, 3'b010);
        tick();
        drive(1'b0, 1'b1, mk(OP_BEQ, 12, 2, 0));
        chk_ctrl("beq_nt", 1'b0, 2'b00, 2'b00, 3'b000);
        tick();
        flush("flush3");

        // Illegal opcode overrides a load-use hazard; exception targets R30
        drive(1'b0, 1'b1, mk(OP_LD, 5, 2, 0));
        tick();
        drive(1'b0, 1'b1, mk(OP_ILL, 1, 5, 5));
        chk_ctrl("illop", 1'b0, 2'b01, 2'b10, 3'b011);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 30, 31));
        chk_ctrl("xp_use", 1'b0, 2'b00, 2'b00, 3'b000);
        chk_byp("xp_use", 2'b01, 2'b00);
        tick();
        drive(1'b0, 1'b0, mk(OP_ILL, 1, 2, 3));
        chk_ctrl("ill_bubble", 1'b0, 2'b00, 2'b01, 3'b000);
        tick();
        flush("flush4");

        // Interrupt held off by supervisor mode, then taken exactly once
        irq = 1'b1; dec_super = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
            chk("irq_super.ack", 32'(irq_ack), 32'd0);
            chk("irq_super.pc", 32'(pc_sel), 32'd0);
            tick();
        end
        dec_super = 1'b0;
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        chk("irq_take.ack", 32'(irq_ack), 32'd1);
        chk_ctrl("irq_take", 1'b0, 2'b01, 2'b10, 3'b100);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
            chk("irq_held.ack", 32'(irq_ack), 32'd0);
            chk_ctrl("irq_held", 1'b0, 2'b00, 2'b00, 3'b000);
            tick();
        end
        irq = 1'b0;
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        chk("irq_drop.ack", 32'(irq_ack), 32'd0);
        tick();
        irq = 1'b1;
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        chk("irq_rise.ack", 32'(irq_ack), 32'd0);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        chk("irq_take2.ack", 32'(irq_ack), 32'd1);
        chk("irq_take2.pc", 32'(pc_sel), 32'd4);
        tick();
        irq = 1'b0;
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        tick();

        // PEND abandoned when irq drops before the take
        irq = 1'b1; dec_super = 1'b1;
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        tick();
        irq = 1'b0; dec_super = 1'b0;
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        chk("pend_drop.ack", 32'(irq_ack), 32'd0);
        tick();
        irq = 1'b1;
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        chk("pend_idle.ack", 32'(irq_ack), 32'd0);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        chk("pend_take.ack", 32'(irq_ack), 32'd1);
        tick();
        irq = 1'b0;
        drive(1'b0, 1'b1, mk(OP_ADD, 13, 2, 3));
        tick();
        flush("flush5");

        // Reset during a load-use stall discards the tracked load
        drive(1'b0, 1'b1, mk(OP_LD, 5, 2, 0));
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 14, 5, 2));
        chk_ctrl("rst_lu1", 1'b1, 2'b00, 2'b01, 3'b000);
        tick();
        drive(1'b1, 1'b1, mk(OP_ADD, 14, 5, 2));
        chk_ctrl("rst_mid", 1'b0, 2'b01, 2'b01, 3'b000);
        chk_byp("rst_mid", 2'b00, 2'b00);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 14, 5, 2));
        chk_ctrl("rst_after", 1'b0, 2'b00, 2'b00, 3'b000);
        chk_byp("rst_after", 2'b00, 2'b00);
        tick();

        // Reset during PEND discards the pending interrupt
        irq = 1'b1; dec_super = 1'b1;
        drive(1'b0, 1'b1, mk(OP_ADD, 15, 2, 3));
        tick();
        dec_super = 1'b0;
        drive(1'b1, 1'b1, mk(OP_ADD, 15, 2, 3));
        chk("rst_pend.ack", 32'(irq_ack), 32'd0);
        chk("rst_pend.pc", 32'(pc_sel), 32'd0);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 15, 2, 3));
        chk("post_rst_idle.ack", 32'(irq_ack), 32'd0);
        tick();
        drive(1'b0, 1'b1, mk(OP_ADD, 15, 2, 3));
        chk("post_rst_take.ack", 32'(irq_ack), 32'd1);
        tick();
        irq = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
